mem_access_unit: RTL and testbench

Load/store access unit between the MIPS datapath and `Data_Mem`. Converts byte-addressed CPU loads and stores of byte, halfword or word size into word-only accesses on `Data_Mem`. Loads are sign- or zero-extended to 32 bits. Sub-word stores run as a two-cycle read-modify-write, and the CPU is stalled for one cycle while it runs.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_access_unit_byte_lane_extract.sv | 31 +++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store access unit: access sizes, FSM states, alignment rule.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    // True when the lane offset cannot hold an access of this size, or the size is illegal.
    function automatic logic isMisaligned(input logic [1:0] offset, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of CPU-side request/response and Data_Mem-side word port for the access unit.
// Latency: n/a (wiring only).
// Backpressure: stall from the unit holds the CPU request; Data_Mem never backpressures.
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    // CPU side
    logic [ADDR_WIDTH+1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [1:0]            cpu_size;
    logic                  cpu_unsigned;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  stall;
    logic                  misaligned;
    // Data_Mem side
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Environment view: drives CPU requests and the memory read data.
    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_size, cpu_unsigned,
        input  cpu_rdata, stall, misaligned,
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en,
        output mem_rdata
    );

    // Access-unit view.
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_size, cpu_unsigned,
        output cpu_rdata, stall, misaligned,
        output mem_addr, mem_wdata, mem_read_en, mem_write_en,
        input  mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_extract.sv
// Picks the byte/halfword lane out of a little-endian word and sign- or zero-extends it.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: word (source word), offset (byte lane), size (SZ_*), isUnsigned, value (extended result).
module byte_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] value
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte = word[8*offset +: 8];
        // Halfwords are always aligned here, so only offset[1] picks the half.
        laneHalf = offset[1] ? word[31:16] : word[15:0];
        value    = '0;
        case (size)
            SZ_BYTE: value = {{24{~isUnsigned & laneByte[7]}}, laneByte};
            SZ_HALF: value = {{16{~isUnsigned & laneHalf[15]}}, laneHalf};
            SZ_WORD: value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Converts byte-addressed CPU loads/stores (byte/half/word) into word-only Data_Mem accesses.
// Latency: loads and word stores 0 cycles; sub-word stores 2 cycles (read, then merge-write).
// Backpressure: stall is raised for the read cycle of a sub-word store; CPU holds its request.
// Ports: clk, rst (sync, active high), bus (mem_access_unit_if.slave: CPU request/response + Data_Mem port).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
)(
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    state_t                stateQ, stateD;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [1:0]            offQ;
    logic [1:0]            sizeQ;
    logic [15:0]           dataQ;
    logic [DATA_WIDTH-1:0] holdQ;

    logic [ADDR_WIDTH-1:0] wordAddr;
    logic [1:0]            laneOff;
    logic                  reqActive;
    logic                  reqBad;
    logic                  capture;
    logic [DATA_WIDTH-1:0] loadValue;
    logic [DATA_WIDTH-1:0] mergedWord;

    assign wordAddr  = bus.cpu_addr[ADDR_WIDTH+1:2];
    assign laneOff   = bus.cpu_addr[1:0];
    assign reqActive = bus.cpu_read | bus.cpu_write;
    assign reqBad    = reqActive & isMisaligned(laneOff, bus.cpu_size);

    byte_lane_extract u_extract (
        .word       (bus.mem_rdata),
        .offset     (laneOff),
        .size       (bus.cpu_size),
        .isUnsigned (bus.cpu_unsigned),
        .value      (loadValue)
    );

    // Overlay the registered store data onto the word read in the previous cycle.
    always_comb begin
        mergedWord = holdQ;
        if (sizeQ == SZ_BYTE) begin
            mergedWord[8*offQ +: 8] = dataQ[7:0];
        end else if (offQ[1]) begin
            mergedWord[31:16] = dataQ;
        end else begin
            mergedWord[15:0] = dataQ;
        end
    end

    always_comb begin
        stateD           = stateQ;
        capture          = 1'b0;
        bus.cpu_rdata    = '0;
        bus.stall        = 1'b0;
        bus.misaligned   = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        case (stateQ)
            IDLE: begin
                bus.misaligned = reqBad;
                if (reqActive && !reqBad) begin
                    bus.mem_addr = wordAddr;
                    // Write wins over read when both are requested.
                    if (bus.cpu_write) begin
                        if (bus.cpu_size == SZ_WORD) begin
                            bus.mem_write_en = 1'b1;
                            bus.mem_wdata    = bus.cpu_wdata;
                        end else begin
                            bus.mem_read_en = 1'b1;
                            bus.stall       = 1'b1;
                            capture         = 1'b1;
                            stateD          = MERGE;
                        end
                    end else begin
                        bus.mem_read_en = 1'b1;
                        bus.cpu_rdata   = loadValue;
                    end
                end
            end
            MERGE: begin
                // Live CPU inputs are ignored here. Reset in this cycle must suppress
                // the write because Data_Mem commits on the same edge that clears us.
                bus.mem_write_en = ~rst;
                bus.mem_addr     = addrQ;
                bus.mem_wdata    = mergedWord;
                stateD           = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            addrQ  <= '0;
            offQ   <= '0;
            sizeQ  <= '0;
            dataQ  <= '0;
            holdQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (capture) begin
                addrQ <= wordAddr;
                offQ  <= laneOff;
                sizeQ <= bus.cpu_size;
                dataQ <= bus.cpu_wdata[15:0];
                holdQ <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   writeCount = 0;
    int   wcStart;
    logic [31:0] mem [0:7];

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data_Mem model: asynchronous gated read, write on rising edge.
    assign bus.mem_rdata = bus.mem_read_en ? mem[bus.mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 2; i < 8; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000FEFA;
            mem[1] <= 32'h0000FBFF;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            writeCount <= writeCount + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic drive_idle();
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        bus.cpu_read     = 1'b0;
        bus.cpu_write    = 1'b0;
        bus.cpu_size     = SZ_WORD;
        bus.cpu_unsigned = 1'b0;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [4:0] addr, input logic [31:0] wd);
        bus.cpu_read     = rd;
        bus.cpu_write    = wr;
        bus.cpu_size     = sz;
        bus.cpu_unsigned = uns;
        bus.cpu_addr     = addr;
        bus.cpu_wdata    = wd;
    endtask

    task automatic do_preload();
        @(negedge clk);
        drive_idle();
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        preload = 1'b1;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
        checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", bus.mem_write_en); end
        checks++; if (bus.mem_read_en !== 1'b0) begin errors++; $display("FAIL rst_ren got %b exp 0", bus.mem_read_en); end
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", bus.misaligned); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.cpu_rdata); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loads();
        @(negedge clk); drive_req(1, 0, SZ_BYTE, 0, 5'd0, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'hFFFFFFFA) begin errors++; $display("FAIL lb0 got %h exp FFFFFFFA", bus.cpu_rdata); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lb0_stall got %b exp 0", bus.stall); end
        checks++; if (bus.mem_read_en !== 1'b1) begin errors++; $display("FAIL lb0_ren got %b exp 1", bus.mem_read_en); end
        @(negedge clk); drive_req(1, 0, SZ_BYTE, 1, 5'd0, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'h000000FA) begin errors++; $display("FAIL lbu0 got %h exp 000000FA", bus.cpu_rdata); end
        @(negedge clk); drive_req(1, 0, SZ_BYTE, 1, 5'd1, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'h000000FE) begin errors++; $display("FAIL lbu1 got %h exp 000000FE", bus.cpu_rdata); end
        @(negedge clk); drive_req(1, 0, SZ_HALF, 0, 5'd4, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'hFFFFFBFF) begin errors++; $display("FAIL lh4 got %h exp FFFFFBFF", bus.cpu_rdata); end
        checks++; if (bus.mem_addr !== 3'd1) begin errors++; $display("FAIL lh4_addr got %0d exp 1", bus.mem_addr); end
        @(negedge clk); drive_req(1, 0, SZ_HALF, 1, 5'd4, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'h0000FBFF) begin errors++; $display("FAIL lhu4 got %h exp 0000FBFF", bus.cpu_rdata); end
        @(negedge clk); drive_req(1, 0, SZ_HALF, 0, 5'd6, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'h00000000) begin errors++; $display("FAIL lh6 got %h exp 00000000", bus.cpu_rdata); end
        @(negedge clk); drive_req(1, 0, SZ_WORD, 0, 5'd0, 0); #1;
        checks++; if (bus.cpu_rdata !== 32'h0000FEFA) begin errors++; $display("FAIL lw0 got %h exp 0000FEFA", bus.cpu_rdata); end
        @(negedge clk); drive_idle(); #1;
        checks++; if (bus.mem_read_en !== 1'b0) begin errors++; $display("FAIL idle_ren got %b exp 0", bus.mem_read_en); end
    endtask

    task automatic test_store_byte();
        do_preload();
        wcStart = writeCount;
        @(negedge clk); drive_req(0, 1, SZ_BYTE, 0, 5'd5, 32'h00000055); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_c0_stall got %b exp 1", bus.stall); end
        checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL sb_c0_wen got %b exp 0", bus.mem_write_en); end
        checks++; if (bus.mem_read_en !== 1'b1) begin errors++; $display("FAIL sb_c0_ren got %b exp 1", bus.mem_read_en); end
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sb_c1_stall got %b exp 0", bus.stall); end
        checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL sb_c1_wen got %b exp 1", bus.mem_write_en); end
        checks++; if (bus.mem_addr !== 3'd1) begin errors++; $display("FAIL sb_c1_addr got %0d exp 1", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h000055FF) begin errors++; $display("FAIL sb_c1_wdata got %h exp 000055FF", bus.mem_wdata); end
        @(negedge clk); drive_idle(); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sb_c2_stall got %b exp 0", bus.stall); end
        checks++; if (mem[1] !== 32'h000055FF) begin errors++; $display("FAIL sb_word1 got %h exp 000055FF", mem[1]); end
        checks++; if (writeCount - wcStart !== 1) begin errors++; $display("FAIL sb_writes got %0d exp 1", writeCount - wcStart); end
    endtask

    task automatic test_store_half();
        do_preload();
        @(negedge clk); drive_req(0, 1, SZ_HALF, 0, 5'd2, 32'hAAAA1234); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sh_c0_stall got %b exp 1", bus.stall); end
        @(negedge clk); #1;
        checks++; if (bus.mem_wdata !== 32'h1234FEFA) begin errors++; $display("FAIL sh_c1_wdata got %h exp 1234FEFA", bus.mem_wdata); end
        @(negedge clk); drive_idle(); #1;
        checks++; if (mem[0] !== 32'h1234FEFA) begin errors++; $display("FAIL sh_word0 got %h exp 1234FEFA", mem[0]); end
    endtask

    task automatic test_back_to_back();
        do_preload();
        wcStart = writeCount;
        @(negedge clk); drive_req(0, 1, SZ_BYTE, 0, 5'd5, 32'h55); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_c0_stall got %b exp 1", bus.stall); end
        @(negedge clk); drive_req(0, 1, SZ_BYTE, 0, 5'd6, 32'h66); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_c1_stall got %b exp 0", bus.stall); end
        checks++; if (bus.mem_wdata !== 32'h000055FF) begin errors++; $display("FAIL b2b_c1_wdata got %h exp 000055FF", bus.mem_wdata); end
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_c2_stall got %b exp 1", bus.stall); end
        checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL b2b_c2_wen got %b exp 0", bus.mem_write_en); end
        @(negedge clk); #1;
        checks++; if (bus.mem_wdata !== 32'h006655FF) begin errors++; $display("FAIL b2b_c3_wdata got %h exp 006655FF", bus.mem_wdata); end
        @(negedge clk); drive_idle(); #1;
        checks++; if (mem[1] !== 32'h006655FF) begin errors++; $display("FAIL b2b_word1 got %h exp 006655FF", mem[1]); end
        checks++; if (writeCount - wcStart !== 2) begin errors++; $display("FAIL b2b_writes got %0d exp 2", writeCount - wcStart); end
    endtask

    task automatic test_misaligned();
        do_preload();
        @(negedge clk); drive_req(0, 1, SZ_WORD, 0, 5'd6, 32'hDEADBEEF); #1;
        checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL sw6_mis got %b exp 1", bus.misaligned); end
        checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL sw6_wen got %b exp 0", bus.mem_write_en); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sw6_stall got %b exp 0", bus.stall); end
        @(negedge clk); drive_req(1, 0, SZ_HALF, 0, 5'd1, 0); #1;
        checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL lh1_mis got %b exp 1", bus.misaligned); end
        checks++; if (bus.mem_read_en !== 1'b0) begin errors++; $display("FAIL lh1_ren got %b exp 0", bus.mem_read_en); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL lh1_rdata got %h exp 0", bus.cpu_rdata); end
        @(negedge clk); drive_req(1, 0, SZ_ILLEGAL, 0, 5'd0, 0); #1;
        checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL sz11_mis got %b exp 1", bus.misaligned); end
        @(negedge clk); drive_req(0, 1, SZ_HALF, 0, 5'd3, 32'h1234); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sh3_stall got %b exp 0", bus.stall); end
        @(negedge clk); drive_idle(); #1;
        checks++; if (mem[1] !== 32'h0000FBFF) begin errors++; $display("FAIL mis_word1 got %h exp 0000FBFF", mem[1]); end
        checks++; if (mem[0] !== 32'h0000FEFA) begin errors++; $display("FAIL mis_word0 got %h exp 0000FEFA", mem[0]); end
    endtask

    task automatic test_reset_mid_store();
        do_preload();
        @(negedge clk); drive_req(0, 1, SZ_BYTE, 0, 5'd0, 32'h77); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rms_c0_stall got %b exp 1", bus.stall); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("FAIL rms_c1_wen got %b exp 0", bus.mem_write_en); end
        @(negedge clk); rst = 1'b0; drive_idle(); #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rms_c2_stall got %b exp 0", bus.stall); end
        checks++; if (mem[0] !== 32'h0000FEFA) begin errors++; $display("FAIL rms_word0 got %h exp 0000FEFA", mem[0]); end
        // An immediately accepted store shows the FSM is back in IDLE.
        @(negedge clk); drive_req(0, 1, SZ_BYTE, 0, 5'd0, 32'h77); #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rms_idle_stall got %b exp 1", bus.stall); end
        @(negedge clk); #1;
        checks++; if (bus.mem_wdata !== 32'h0000FE77) begin errors++; $display("FAIL rms_wdata got %h exp 0000FE77", bus.mem_wdata); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_read_write();
        do_preload();
        @(negedge clk); drive_req(1, 1, SZ_WORD, 0, 5'd0, 32'hCAFEBABE); #1;
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rw_rdata got %h exp 0", bus.cpu_rdata); end
        checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL rw_wen got %b exp 1", bus.mem_write_en); end
        checks++; if (bus.mem_read_en !== 1'b0) begin errors++; $display("FAIL rw_ren got %b exp 0", bus.mem_read_en); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rw_stall got %b exp 0", bus.stall); end
        @(negedge clk); drive_idle(); #1;
        checks++; if (mem[0] !== 32'hCAFEBABE) begin errors++; $display("FAIL rw_word0 got %h exp CAFEBABE", mem[0]); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_loads();
        test_store_byte();
        test_store_half();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_store();
        test_read_write();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
